// File: rtl/des_round_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : des_round_controller_pkg
//  Description : Shared definitions for the iterative DES round controller.
//                Holds the IP / FP / PC-1 / PC-2 permutation tables, the key
//                rotation schedule, the controller state encoding and the
//                permutation / rotation helper functions.
//                Bit convention: vector index i == DES bit i+1, so index 0 is
//                the leftmost DES bit. Table entries are 1-based DES bit
//                numbers; the helpers convert them to vector indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package des_round_controller_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Initial permutation: output bit i takes input DES bit C_IP_TAB[i]
  localparam int C_IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
  };

  // Final permutation (inverse of IP)
  localparam int C_FP_TAB [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
  };

  // PC-1: first 28 outputs form C0, last 28 form D0; parity bits are dropped
  localparam int C_PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: selects the 48-bit round subkey from C||D
  localparam int C_PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Rotation schedule: bit k set means round k+1 rotates by 2, else by 1.
  // Rounds 1,2,9,16 rotate by 1; total over 16 rounds is 28.
  localparam logic [15:0] C_SH_TWO = 16'h7EFC;

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      y[i] = x[6'(C_IP_TAB[i] - 1)];
    end
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      y[i] = x[6'(C_FP_TAB[i] - 1)];
    end
    return y;
  endfunction

  function automatic logic [55:0] des_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) begin
      y[i] = x[6'(C_PC1_TAB[i] - 1)];
    end
    return y;
  endfunction

  // Input is C||D in index order: {D, C} as an SV concatenation
  function automatic logic [47:0] des_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) begin
      y[i] = x[6'(C_PC2_TAB[i] - 1)];
    end
    return y;
  endfunction

  // DES left rotate: new X[i] = X[(i+s) mod 28]. With index 0 leftmost this
  // is a numeric right rotation of the SV vector.
  function automatic logic [27:0] des_rotl(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Exact inverse of des_rotl
  function automatic logic [27:0] des_rotr(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_round_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : des_round_controller_if
//  Description : Job / result / f-function bus of the DES round controller.
//    in_valid  : block/key/decrypt valid          in_ready : controller idle
//    block     : 64-bit input block               key      : 64-bit DES key
//    decrypt   : 0 = encrypt, 1 = decrypt
//    fr        : R half to f-function             fk       : round subkey
//    f_in      : f(fr, fk), combinational return
//    out_valid : result valid                     out_ready: consumer ready
//    result    : 64-bit output block              round    : trace index
//    Modports: slave = controller view, master = environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface des_round_controller_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] block;
  logic [63:0] key;
  logic        decrypt;
  logic [31:0] fr;
  logic [47:0] fk;
  logic [31:0] f_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [3:0]  round;

  modport slave (
    input  in_valid, block, key, decrypt, f_in, out_ready,
    output in_ready, fr, fk, out_valid, result, round
  );

  modport master (
    output in_valid, block, key, decrypt, f_in, out_ready,
    input  in_ready, fr, fk, out_valid, result, round
  );
endinterface
`default_nettype wire

// File: rtl/des_round_controller_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : des_round_controller_key_schedule
//  Description : Holds the C/D key halves, loads them from PC-1 on job
//                accept and rotates them once per round, emitting the PC-2
//                subkey for the current round.
//    i_clk      : clock                   i_rst_n  : sync reset, active-low
//    i_load     : load C/D from PC1(i_key)
//    i_key      : 64-bit DES key
//    i_advance  : a round completes on this edge
//    i_decrypt  : latched job mode        i_round  : current round index 0..15
//    o_subkey   : 48-bit subkey for the current round
//  Revision    : 1.0 - initial release
// ============================================================================
module des_round_controller_key_schedule
  import des_round_controller_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [63:0] i_key,
  input  logic        i_advance,
  input  logic        i_decrypt,
  input  logic [3:0]  i_round,
  output logic [47:0] o_subkey
);

  logic [27:0] r_c;
  logic [27:0] r_d;

  logic [55:0] w_pc1;
  logic [3:0]  w_sh_idx;
  logic        w_two;
  logic [27:0] w_c_rot;
  logic [27:0] w_d_rot;
  logic [55:0] w_cd_sel;

  always_comb begin
    w_pc1 = des_pc1(i_key);

    // Encrypt round r uses SH[r] = bit (round); decrypt uses SH[17-r],
    // i.e. bit (15 - round), since the schedule is walked backwards.
    w_sh_idx = i_decrypt ? (4'd15 - i_round) : i_round;
    w_two    = C_SH_TWO[w_sh_idx];

    if (i_decrypt) begin
      w_c_rot = des_rotr(r_c, w_two);
      w_d_rot = des_rotr(r_d, w_two);
    end else begin
      w_c_rot = des_rotl(r_c, w_two);
      w_d_rot = des_rotl(r_d, w_two);
    end

    // Encrypt rotates before PC-2; decrypt uses the stored halves and
    // rotates afterwards, so C0/D0 directly yield K16 in round 1.
    if (i_advance && !i_decrypt) begin
      w_cd_sel = {w_d_rot, w_c_rot};
    end else begin
      w_cd_sel = {r_d, r_c};
    end

    o_subkey = des_pc2(w_cd_sel);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_c <= '0;
      r_d <= '0;
    end else if (i_load) begin
      r_c <= w_pc1[27:0];
      r_d <= w_pc1[55:28];
    end else if (i_advance) begin
      r_c <= w_c_rot;
      r_d <= w_d_rot;
    end
  end

endmodule
`default_nettype wire

// File: rtl/des_round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : des_round_controller
//  Description : Iterative DES engine controller. Accepts one block + key,
//                applies IP, runs 16 Feistel rounds (one per clock) using an
//                external combinational f-function, then applies FP and
//                presents the result with a valid/ready handshake.
//    i_clk   : clock, all state on rising edge
//    i_rst_n : synchronous reset, active-low
//    bus     : des_round_controller_if.slave (job in, result out, f-function)
//  Revision    : 1.0 - initial release
// ============================================================================
module des_round_controller
  import des_round_controller_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  des_round_controller_if.slave  bus
);

  state_t      r_state;
  state_t      w_state_next;

  logic [3:0]  r_round;
  logic [31:0] r_l;
  logic [31:0] r_r;
  logic [63:0] r_result;
  logic        r_out_valid;
  logic        r_decrypt;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_in_round;
  logic        w_last;
  logic [63:0] w_ip;
  logic [31:0] w_r_next;
  logic [47:0] w_subkey;

  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_in_round = (r_state == ST_ROUND);
  assign w_last     = (r_round == 4'd15);
  assign w_ip       = des_ip(bus.block);
  assign w_r_next   = r_l ^ bus.f_in;

  des_round_controller_key_schedule u_key_schedule (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_accept),
    .i_key     (bus.key),
    .i_advance (w_in_round),
    .i_decrypt (r_decrypt),
    .i_round   (r_round),
    .o_subkey  (w_subkey)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)      w_state_next = ST_ROUND;
      ST_ROUND: if (w_last)        w_state_next = ST_DONE;
      ST_DONE:  if (bus.out_ready) w_state_next = ST_IDLE;
      default:                     w_state_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    w_in_ready    = (r_state == ST_IDLE);
    bus.in_ready  = w_in_ready;
    bus.round     = w_in_round ? r_round : 4'd0;
    bus.fr        = r_r;
    bus.fk        = w_subkey;
    bus.out_valid = r_out_valid;
    bus.result    = r_result;
  end

  // Feistel datapath, round counter and result register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_round     <= 4'd0;
      r_l         <= '0;
      r_r         <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_decrypt   <= 1'b0;
    end else if (w_accept) begin
      r_l       <= w_ip[31:0];
      r_r       <= w_ip[63:32];
      r_decrypt <= bus.decrypt;
      r_round   <= 4'd0;
    end else if (w_in_round) begin
      r_l     <= r_r;
      r_r     <= w_r_next;
      // Wraps back to 0 after round 15, ready for the next job
      r_round <= r_round + 4'd1;
      if (w_last) begin
        // Preoutput swaps halves: left = R16 (indices 0..31), right = L16
        r_result    <= des_fp({r_r, w_r_next});
        r_out_valid <= 1'b1;
      end
    end else if ((r_state == ST_DONE) && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
